// File: rtl/spi_byte_engine_if.sv
// Command strobe, serial lines and status between ctrl decoder, SPI sockets and the byte engine.
interface spi_byte_engine_if;
   logic       CMD_WE;
   logic [1:0] CMD_OP;
   logic [7:0] CMD_DATA;
   logic [2:0] MISO;
   logic       SCK;
   logic       MOSI;
   logic [1:0] nSS;
   logic [7:0] RX_DATA;
   logic       BUSY;
   logic       DONE;
   logic       OVR;

   modport master (
      output CMD_WE, CMD_OP, CMD_DATA, MISO,
      input  SCK, MOSI, nSS, RX_DATA, BUSY, DONE, OVR
   );

   modport slave (
      input  CMD_WE, CMD_OP, CMD_DATA, MISO,
      output SCK, MOSI, nSS, RX_DATA, BUSY, DONE, OVR
   );
endinterface

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI master moving one byte per command; replaces bit-banged SCK/MOSI on the Gigatron.
module spi_byte_engine #(
   parameter int DIVW    = 4,
   parameter int DIV_RST = 3,
   parameter int LEAD    = 2
) (
   input logic               CLKx4,
   input logic               RESET,
   spi_byte_engine_if.slave  bus
);
   localparam logic [1:0] OP_XFER = 2'b00;
   localparam logic [1:0] OP_NSS  = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;
   localparam int         LCW     = $clog2(LEAD + 2);

   typedef enum logic [1:0] {IDLE, LEADIN, SHIFT, LEADOUT} state_t;

   state_t            state;
   logic [LCW-1:0]    lcnt;
   logic [DIVW-1:0]   dcnt;
   logic [DIVW-1:0]   div;
   logic [3:0]        hcnt;
   logic [7:0]        shreg;
   logic [7:0]        rx;
   logic [1:0]        nss;
   logic              sck;
   logic              mosi;
   logic              busy;
   logic              done;
   logic              ovr;
   logic              misox;
   logic              sync1;
   logic              sync2;

   assign misox = (bus.MISO[0] & ~nss[0]) | (bus.MISO[1] & ~nss[1]) |
                  (bus.MISO[2] & nss[0] & nss[1]);

   always_ff @(posedge CLKx4) begin
      sync1 <= misox;
      sync2 <= sync1;
   end

   always_ff @(posedge CLKx4 or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         lcnt  <= '0;
         dcnt  <= '0;
         div   <= DIVW'(DIV_RST);
         hcnt  <= 4'd0;
         shreg <= 8'h00;
         rx    <= 8'h00;
         nss   <= 2'b11;
         sck   <= 1'b0;
         mosi  <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
         ovr   <= 1'b0;
      end else begin
         if (bus.CMD_WE) begin
            case (bus.CMD_OP)
               OP_CLR: begin
                  done <= 1'b0;
                  ovr  <= 1'b0;
               end
               OP_NSS: begin
                  if (busy) ovr <= 1'b1;
                  else      nss <= bus.CMD_DATA[1:0];
               end
               OP_DIV: begin
                  if (busy) ovr <= 1'b1;
                  else      div <= bus.CMD_DATA[DIVW-1:0];
               end
               default: begin
                  if (busy) ovr  <= 1'b1;
                  else      done <= 1'b0;
               end
            endcase
         end

         // FSM assignments follow the command decode so a completing transfer
         // overrides a clear arriving on the same edge.
         case (state)
            IDLE: begin
               sck  <= 1'b0;
               mosi <= 1'b1;
               if (bus.CMD_WE && bus.CMD_OP == OP_XFER) begin
                  shreg <= bus.CMD_DATA;
                  mosi  <= bus.CMD_DATA[7];
                  busy  <= 1'b1;
                  lcnt  <= '0;
                  state <= LEADIN;
               end
            end
            LEADIN: begin
               if (lcnt == LCW'(LEAD - 1)) begin
                  sck   <= 1'b1;
                  dcnt  <= '0;
                  hcnt  <= 4'd0;
                  state <= SHIFT;
               end else begin
                  lcnt <= lcnt + 1'b1;
               end
            end
            SHIFT: begin
               if (dcnt == div) begin
                  dcnt <= '0;
                  if (hcnt == 4'd15) begin
                     sck   <= 1'b0;
                     hcnt  <= 4'd0;
                     lcnt  <= '0;
                     state <= LEADOUT;
                  end else begin
                     hcnt <= hcnt + 4'd1;
                     // hcnt even means SCK is high now, so this boundary is a falling edge
                     if (!hcnt[0]) begin
                        sck   <= 1'b0;
                        shreg <= {shreg[6:0], sync2};
                        mosi  <= shreg[6];
                     end else begin
                        sck <= 1'b1;
                     end
                  end
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            LEADOUT: begin
               if (lcnt == LCW'(LEAD)) begin
                  rx    <= shreg;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  mosi  <= 1'b1;
                  state <= IDLE;
               end else begin
                  lcnt <= lcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.SCK     = sck;
   assign bus.MOSI    = mosi;
   assign bus.nSS     = nss;
   assign bus.RX_DATA = rx;
   assign bus.BUSY    = busy;
   assign bus.DONE    = done;
   assign bus.OVR     = ovr;
endmodule

// File: tb/tb_spi_byte_engine.sv
// Bench for spi_byte_engine: vector table, hand-written corner sequences and randomized transfers.
module tb_spi_byte_engine;
   localparam int LEAD = 2;
   localparam logic [1:0] OP_XFER = 2'b00;
   localparam logic [1:0] OP_NSS  = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   typedef struct {
      logic [1:0] nss;
      logic [3:0] div;
      logic [7:0] tx;
      logic [2:0] miso;
      bit         lp;
      logic [7:0] exp_rx;
      int         exp_w;
   } vec_t;

   logic       CLKx4 = 1'b0;
   logic       RESET;
   logic [2:0] mstat;
   bit         loop;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         sck_rises = 0;
   int         sck_edges = 0;
   logic [7:0] mosi_cap = 8'h00;
   vec_t       tbl[9];

   spi_byte_engine_if bus();

   spi_byte_engine #(.DIVW(4), .DIV_RST(3), .LEAD(LEAD)) dut (
      .CLKx4 (CLKx4),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLKx4 = ~CLKx4;

   assign bus.MISO = loop ? {mstat[2:1], bus.MOSI} : mstat;

   always @(posedge CLKx4) cyc <= cyc + 1;

   always @(posedge bus.SCK) begin
      sck_rises <= sck_rises + 1;
      mosi_cap  <= {mosi_cap[6:0], bus.MOSI};
   end

   always @(bus.SCK) sck_edges = sck_edges + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cmd(input logic [1:0] op, input logic [7:0] d);
      @(negedge CLKx4);
      bus.CMD_WE = 1'b1; bus.CMD_OP = op; bus.CMD_DATA = d;
      @(negedge CLKx4);
      bus.CMD_WE = 1'b0;
   endtask

   task automatic wait_idle(input int t0, output int w);
      int n;
      n = 0;
      while (bus.BUSY === 1'b1 && n < 3000) begin
         @(negedge CLKx4);
         n++;
      end
      chk("busy_released", {31'd0, bus.BUSY}, 32'd0);
      w = cyc - t0;
   endtask

   function automatic logic [7:0] model_rx(input logic [1:0] nss, input logic [2:0] miso,
                                            input bit lp, input logic [7:0] tx);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         bit line0;
         line0 = lp ? tx[i] : miso[0];
         r[i] = (line0 & !nss[0]) | (miso[1] & !nss[1]) | (miso[2] & nss[0] & nss[1]);
      end
      return r;
   endfunction

   function automatic int model_w(input logic [3:0] div);
      return 2 * LEAD + 16 * (int'(div) + 1) + 1;
   endfunction

   task automatic run_xfer(input logic [1:0] nss, input logic [3:0] div, input logic [7:0] tx,
                           input logic [2:0] miso, input bit lp, output int w, output int rises);
      int t0, r0;
      cmd(OP_NSS, {6'd0, nss});
      cmd(OP_DIV, {4'd0, div});
      mstat = miso;
      loop  = lp;
      repeat (3) @(negedge CLKx4);
      r0 = sck_rises;
      cmd(OP_XFER, tx);
      t0 = cyc;
      wait_idle(t0, w);
      rises = sck_rises - r0;
   endtask

   task automatic verify(input string tag, input logic [1:0] nss, input logic [7:0] tx,
                         input logic [7:0] exp_rx, input int exp_w, input int w, input int rises);
      chk({tag, "_rx"},    {24'd0, bus.RX_DATA}, {24'd0, exp_rx});
      chk({tag, "_width"}, w, exp_w);
      chk({tag, "_pulses"}, rises, 8);
      chk({tag, "_mosi_stream"}, {24'd0, mosi_cap}, {24'd0, tx});
      chk({tag, "_done"},  {31'd0, bus.DONE}, 32'd1);
      chk({tag, "_ovr"},   {31'd0, bus.OVR}, 32'd0);
      chk({tag, "_idle_lines"}, {30'd0, bus.SCK, bus.MOSI}, 32'd1);
      chk({tag, "_nss"},   {30'd0, bus.nSS}, {30'd0, nss});
   endtask

   initial begin
      int w, rises, t0, r0, e0, n;
      logic [1:0] rn;
      logic [3:0] rd;
      logic [7:0] rt;
      logic [2:0] rm;
      bit         rl;

      tbl[0] = '{2'b10, 4'd3, 8'hA5, 3'b000, 1'b1, 8'hA5, 69};
      tbl[1] = '{2'b10, 4'd0, 8'h3C, 3'b000, 1'b0, 8'h00, 21};
      tbl[2] = '{2'b10, 4'd7, 8'h3C, 3'b000, 1'b0, 8'h00, 133};
      tbl[3] = '{2'b11, 4'd3, 8'h00, 3'b100, 1'b0, 8'hFF, 69};
      tbl[4] = '{2'b10, 4'd3, 8'h5A, 3'b110, 1'b0, 8'h00, 69};
      tbl[5] = '{2'b01, 4'd1, 8'hC3, 3'b010, 1'b0, 8'hFF, 37};
      tbl[6] = '{2'b00, 4'd2, 8'h81, 3'b001, 1'b0, 8'hFF, 53};
      tbl[7] = '{2'b10, 4'd1, 8'h96, 3'b000, 1'b1, 8'h96, 37};
      tbl[8] = '{2'b11, 4'd0, 8'h7E, 3'b011, 1'b0, 8'h00, 21};

      RESET = 1'b1;
      bus.CMD_WE = 1'b0; bus.CMD_OP = 2'b00; bus.CMD_DATA = 8'h00;
      mstat = 3'b000; loop = 1'b0;
      repeat (3) @(negedge CLKx4);
      chk("reset_outputs", {bus.SCK, bus.MOSI, bus.nSS, bus.BUSY, bus.DONE, bus.OVR, bus.RX_DATA},
          {1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00});
      RESET = 1'b0;
      repeat (2) @(negedge CLKx4);
      chk("post_reset_idle", {bus.SCK, bus.MOSI, bus.nSS, bus.BUSY, bus.DONE, bus.OVR, bus.RX_DATA},
          {1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00});

      for (int i = 0; i < 9; i++) begin
         run_xfer(tbl[i].nss, tbl[i].div, tbl[i].tx, tbl[i].miso, tbl[i].lp, w, rises);
         verify($sformatf("vec%0d", i), tbl[i].nss, tbl[i].tx, tbl[i].exp_rx, tbl[i].exp_w, w, rises);
      end

      // Commands during a transfer: only op11 takes effect, the rest raise OVR.
      cmd(OP_NSS, 8'h02); cmd(OP_DIV, 8'h03);
      mstat = 3'b000; loop = 1'b1;
      repeat (3) @(negedge CLKx4);
      r0 = sck_rises;
      cmd(OP_XFER, 8'hA5);
      t0 = cyc;
      repeat (3) @(negedge CLKx4);
      cmd(OP_XFER, 8'hFF);
      chk("ovr_set_by_busy_xfer", {30'd0, bus.OVR, bus.BUSY}, 32'd3);
      cmd(OP_NSS, 8'h01);
      chk("nss_ignored_busy", {30'd0, bus.nSS}, 32'd2);
      cmd(OP_DIV, 8'h00);
      wait_idle(t0, w);
      chk("ovr_xfer_width", w, 69);
      chk("ovr_xfer_rx", {24'd0, bus.RX_DATA}, 32'hA5);
      chk("ovr_xfer_stream", {24'd0, mosi_cap}, 32'hA5);
      chk("ovr_xfer_pulses", sck_rises - r0, 8);
      chk("ovr_sticky_done", {30'd0, bus.OVR, bus.DONE}, 32'd3);
      cmd(OP_CLR, 8'h00);
      chk("clear_flags", {30'd0, bus.OVR, bus.DONE}, 32'd0);

      // Clear arriving on the very edge the transfer completes: DONE must survive.
      cmd(OP_DIV, 8'h00);
      repeat (3) @(negedge CLKx4);
      cmd(OP_XFER, 8'h11);
      repeat (20) @(negedge CLKx4);
      chk("busy_before_final_edge", {31'd0, bus.BUSY}, 32'd1);
      bus.CMD_WE = 1'b1; bus.CMD_OP = OP_CLR; bus.CMD_DATA = 8'h00;
      @(negedge CLKx4);
      bus.CMD_WE = 1'b0;
      chk("done_set_wins", {30'd0, bus.DONE, bus.BUSY}, 32'd2);
      cmd(OP_CLR, 8'h00);
      chk("done_cleared_later", {31'd0, bus.DONE}, 32'd0);

      // Asynchronous reset in the middle of the shift phase.
      cmd(OP_DIV, 8'h03);
      repeat (3) @(negedge CLKx4);
      cmd(OP_XFER, 8'hE7);
      e0 = sck_edges;
      n = 0;
      while ((sck_edges - e0) < 4 && n < 500) begin
         @(negedge CLKx4);
         n++;
      end
      chk("reached_4th_edge", {31'd0, bus.BUSY}, 32'd1);
      #1 RESET = 1'b1;
      #1;
      chk("midreset_outputs", {bus.SCK, bus.nSS, bus.BUSY, bus.DONE, bus.MOSI, bus.RX_DATA},
          {1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00});
      @(posedge CLKx4);
      @(negedge CLKx4);
      RESET = 1'b0;
      cmd(OP_NSS, 8'h02);
      mstat = 3'b000; loop = 1'b1;
      repeat (3) @(negedge CLKx4);
      cmd(OP_XFER, 8'h3A);
      t0 = cyc;
      wait_idle(t0, w);
      chk("recover_default_div_width", w, 69);
      chk("recover_rx", {24'd0, bus.RX_DATA}, 32'h3A);

      for (int k = 0; k < 24; k++) begin
         rn = 2'($urandom_range(0, 3));
         rl = 1'($urandom_range(0, 1));
         rd = rl ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
         rt = 8'($urandom);
         rm = 3'($urandom_range(0, 7));
         run_xfer(rn, rd, rt, rm, rl, w, rises);
         verify($sformatf("rnd%0d", k), rn, rt, model_rx(rn, rm, rl, rt), model_w(rd), w, rises);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
